// File: rtl/rom_fetch_controller_pkg.sv
// Shared types for the ROM fetch controller: instruction-cycle phases and fill byte.
package rom_fetch_controller_pkg;

  // Eight CPU phases in 3 bits; bit 3 marks the unsynchronised idle state.
  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_IDLE = 4'd8
  } phase_e;

  localparam logic [7:0] NOP_BYTE = 8'h00;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_A1:   return PH_A2;
      PH_A2:   return PH_A3;
      PH_A3:   return PH_M1;
      PH_M1:   return PH_M2;
      PH_M2:   return PH_X1;
      PH_X1:   return PH_X2;
      PH_X2:   return PH_X3;
      PH_X3:   return PH_A1;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rom_fetch_controller_if.sv
// Byte-wide program-store request/valid bus between the fetch controller and the store.
interface rom_fetch_controller_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/rom_fetch_controller_timeout.sv
// Counts cycles a request has been outstanding; flags the last permitted wait cycle.
module rom_fetch_controller_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expire_o = run_i && (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/rom_fetch_controller.sv
// Memory-side sequencer for the 4-bit CPU bus: tracks phases, fetches the
// instruction byte from the program store and returns OPR/OPA in M1/M2.
module rom_fetch_controller
  import rom_fetch_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  FILL_BYTE      = NOP_BYTE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sync,
  input  logic [3:0]                    data_i,
  output logic [3:0]                    data_o,
  output logic                          data_en,
  output logic                          halt,
  output logic                          fetch_err,
  rom_fetch_controller_if.master        mem
);

  phase_e      phase_q, phase_d;
  logic [7:0]  addr_lo_q;
  logic [11:0] mem_addr_q;
  logic        mem_req_q;
  logic [7:0]  buf_q;
  logic        buf_full_q;
  logic        stalled_q;
  logic        fetch_err_q;

  logic expire, timeout_hit, fill_now, in_m1, bypass, step;

  rom_fetch_controller_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .run_i   (mem_req_q),
    .expire_o(expire)
  );

  assign fill_now    = mem_req_q && mem.mem_valid;
  assign timeout_hit = expire && !mem.mem_valid;
  assign in_m1       = (phase_q == PH_M1);
  // A byte arriving in the first M1 cycle is forwarded straight to the bus so
  // a zero-wait store never stalls; once stalled, halt covers the capture cycle.
  assign bypass      = in_m1 && !buf_full_q && !stalled_q && fill_now;
  assign halt        = in_m1 && !buf_full_q && !bypass;
  assign step        = !halt;

  always_comb begin
    phase_d = phase_q;
    if (step) begin
      phase_d = sync ? PH_A1 : next_phase(phase_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= PH_IDLE;
      addr_lo_q   <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      stalled_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      stalled_q   <= halt;
      fetch_err_q <= timeout_hit;

      if (step) begin
        case (phase_q)
          PH_A1: addr_lo_q[3:0] <= data_i;
          PH_A2: addr_lo_q[7:4] <= data_i;
          PH_A3: begin
            if (!sync) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {data_i, addr_lo_q};
            end
          end
          default: ;
        endcase
      end

      if (fill_now) begin
        buf_q      <= mem.mem_rdata;
        buf_full_q <= 1'b1;
        mem_req_q  <= 1'b0;
      end else if (timeout_hit) begin
        buf_q      <= FILL_BYTE;
        buf_full_q <= 1'b1;
        mem_req_q  <= 1'b0;
      end

      // Leaving M2 or resynchronising discards the byte so it is never replayed.
      if (step && (sync || (phase_q == PH_M2))) begin
        buf_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    data_o  = '0;
    data_en = 1'b0;
    case (phase_q)
      PH_M1: begin
        if (buf_full_q) begin
          data_o  = buf_q[7:4];
          data_en = 1'b1;
        end else if (bypass) begin
          data_o  = mem.mem_rdata[7:4];
          data_en = 1'b1;
        end
      end
      PH_M2: begin
        data_o  = buf_q[3:0];
        data_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_rom_fetch_controller.sv
// Bench acting as CPU and program store around rom_fetch_controller.
module tb_rom_fetch_controller;
  import rom_fetch_controller_pkg::*;

  localparam int unsigned TO   = 6;
  localparam logic [7:0]  FILL = 8'h00;

  logic       clock = 1'b0;
  logic       reset;
  logic       sync;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;
  logic       halt;
  logic       fetch_err;

  rom_fetch_controller_if mem ();

  rom_fetch_controller #(
    .TIMEOUT_CYCLES(TO),
    .FILL_BYTE     (FILL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sync     (sync),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_en  (data_en),
    .halt     (halt),
    .fetch_err(fetch_err),
    .mem      (mem.master)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  rom [4096];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: inputs change on the falling edge, outputs sampled 1 ns later.
  task automatic drive(input logic s, input logic [3:0] d, input logic v, input logic [7:0] rd);
    @(negedge clock);
    sync          = s;
    data_i        = d;
    mem.mem_valid = v;
    mem.mem_rdata = rd;
    #1;
  endtask

  // One instruction cycle: sync cycle, A1-A3 nibbles, M1 (with stall), M2, then
  // 'tail' X cycles before the next sync. The store answers 'lat' cycles after req.
  task automatic do_instr(input logic [11:0] a, input int unsigned lat, input bit late,
                          input int unsigned tail);
    logic [7:0]  eb;
    logic [3:0]  nib;
    int unsigned eh, er, n, hc, rc, ec;
    bit          ok;
    eb = (lat < TO) ? rom[a] : FILL;
    eh = (lat == 0) ? 0 : ((lat < TO) ? lat + 1 : TO);
    er = (lat < TO) ? lat + 1 : TO;

    drive(1'b1, 4'h0, 1'b0, 8'h00);
    check_eq("sync_den", data_en, 0);
    check_eq("sync_halt", halt, 0);
    for (int i = 0; i < 3; i++) begin
      nib = a[i*4 +: 4];
      drive(1'b0, nib, 1'b0, 8'h00);
      check_eq("a_den", data_en, 0);
      check_eq("a_req", mem.mem_req, 0);
      check_eq("a_halt", halt, 0);
    end

    n = 0; hc = 0; rc = 0; ec = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      drive(1'b0, 4'h0, (n == lat), rom[a]);
      if (n == 0) check_eq("m1_addr", mem.mem_addr, a);
      check_eq("m1_req", mem.mem_req, (n < er));
      if (mem.mem_req) rc++;
      if (fetch_err) ec++;
      if (halt) begin
        hc++;
        check_eq("stall_den", data_en, 0);
      end else begin
        ok = 1'b1;
        check_eq("m1_den", data_en, 1);
        check_eq("m1_opr", data_o, eb[7:4]);
      end
      n++;
    end
    check_eq("m1_exit", ok, 1);
    check_eq("halt_cycles", hc, eh);
    check_eq("req_cycles", rc, er);

    drive(1'b0, 4'h0, late, ~eb);
    check_eq("m2_den", data_en, 1);
    check_eq("m2_opa", data_o, eb[3:0]);
    check_eq("m2_halt", halt, 0);
    check_eq("m2_req", mem.mem_req, 0);
    if (fetch_err) ec++;

    for (int i = 0; i < int'(tail); i++) begin
      drive(1'b0, 4'h0, late && (i == 0), ~eb);
      check_eq("x_den", data_en, 0);
      check_eq("x_halt", halt, 0);
      if (fetch_err) ec++;
    end
    check_eq("err_pulses", ec, (lat >= TO) ? 1 : 0);
  endtask

  task automatic reset_in_stall(input logic [11:0] a);
    drive(1'b1, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b0, a[i*4 +: 4], 1'b0, 8'h00);
    drive(1'b0, 4'h0, 1'b0, 8'h00);
    check_eq("rst_pre_halt", halt, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    drive(1'b0, 4'h0, 1'b0, 8'h00);
    reset = 1'b0;
    check_eq("rst_halt", halt, 0);
    check_eq("rst_req", mem.mem_req, 0);
    check_eq("rst_den", data_en, 0);
    check_eq("rst_err", fetch_err, 0);
    // Without sync the controller must stay idle and never issue a request.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'hA, 1'b0, 8'h00);
      check_eq("idle_req", mem.mem_req, 0);
      check_eq("idle_den", data_en, 0);
      check_eq("idle_halt", halt, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h123] = 8'hD5;
    reset         = 1'b1;
    sync          = 1'b0;
    data_i        = 4'h0;
    mem.mem_valid = 1'b0;
    mem.mem_rdata = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_data_o", data_o, 0);
    check_eq("rst_data_en", data_en, 0);
    check_eq("rst_halt0", halt, 0);
    check_eq("rst_mem_req", mem.mem_req, 0);
    check_eq("rst_mem_addr", mem.mem_addr, 0);
    check_eq("rst_fetch_err", fetch_err, 0);
    reset = 1'b0;

    do_instr(12'h123, 0, 1'b0, 2);        // zero-wait
    do_instr(12'h456, 5, 1'b0, 2);        // five wait cycles
    do_instr(12'h789, 20, 1'b1, 2);       // silent store, late strobes
    do_instr(12'h9AB, TO, 1'b0, 0);       // strobe one cycle too late; resync in X1
    do_instr(12'h5A5, 2, 1'b0, 2);
    reset_in_stall(12'h321);
    do_instr(12'h0F0, 1, 1'b0, 2);
    do_instr(12'hFFF, 1, 1'b0, 2);        // back-to-back with wrap
    do_instr(12'h000, 0, 1'b0, 2);
    do_instr(12'h001, 3, 1'b0, 2);

    for (int k = 0; k < 40; k++) begin
      do_instr(12'($urandom), $urandom_range(0, TO + 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_controller.md
Name: rom_fetch_controller

Overview:
- Memory-side sequencer for the 4-bit CPU bus.
- Tracks the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from the CPU's sync output.
- Assembles the 12-bit fetch address from the three A-phase nibbles and fetches the byte from an external byte-wide program store over a req/valid handshake.
- Returns OPR/OPA nibbles in M1/M2, and drives the CPU halt input to stall when the store is slow.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles mem_req may wait for mem_valid; 0 disables the timeout.
- FILL_BYTE, 8'h00: byte returned on timeout (NOP).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sync  input  1  CPU sync; high during the non-halted cycle preceding A1
- data_i  input  4  CPU bus nibble (address output of CPU)
- data_o  output  4  nibble driven to CPU bus
- data_en  output  1  data_o valid/driving
- halt  output  1  CPU stall request
- mem_req  output  1  fetch request to program store
- mem_addr  output  12  fetch address; stable while mem_req high
- mem_rdata  input  8  fetched byte
- mem_valid  input  1  one-cycle strobe; mem_rdata valid
- fetch_err  output  1  one-cycle pulse on timeout

Behaviour:
- Interface:
  - One clock, named clock.
  - Reset is synchronous and active-high, named reset; these are fixed.
- Reset values:
  - phase=IDLE; data_o=0, data_en=0, halt=0, mem_req=0, mem_addr=0, fetch_err=0.
  - Byte buffer empty.
- Phase FSM: IDLE, A1, A2, A3, M1, M2, X1, X2, X3. A "step" is a cycle with halt low.
  - sync high in a step moves to A1 from any state, which resynchronises after a glitch or mid-cycle start.
  - Otherwise, each step advances A1→A2→…→X3→A1.
  - The FSM holds its state in any cycle with halt high.
  - sync is ignored while halt is high.
- Address capture: in the A1, A2 and A3 steps, latch data_i into addr[3:0], addr[7:4] and addr[11:8] respectively.
- Request: the cycle after the A3 step:
  - mem_req goes high and mem_addr takes the assembled address.
  - mem_req stays high until the cycle mem_valid is seen; mem_valid without mem_req is ignored.
  - mem_rdata is captured into the buffer on mem_valid, and mem_req drops the next cycle.
  - Zero-wait store (valid in the same cycle as req) gives no stall.
- Stall:
  - In M1, halt is high combinationally whenever the buffer is empty.
  - The cycle the byte is captured, halt is still high; it drops the following cycle.
  - halt is never asserted in any other phase.
- Drive:
  - In M1, data_o=buffer[7:4] and data_en=1, only when the buffer is full; otherwise data_en=0.
  - In M2, data_o=buffer[3:0] and data_en=1.
  - The buffer is cleared on leaving M2.
  - data_en=0 in all A and X phases (no I/O port support).
- Timeout:
  - A counter runs while mem_req is high.
  - When it reaches TIMEOUT_CYCLES:
    - load FILL_BYTE into the buffer;
    - drop mem_req;
    - pulse fetch_err for 1 cycle.
  - A late mem_valid is then ignored until the next request.
- Two-word instructions need no special handling: each instruction cycle performs its own fetch.
- Reset mid-fetch:
  - All state clears and mem_req drops the same cycle reset is sampled.
  - The store must tolerate request abandonment.

Decomposition:
- Shared package:
  - phase enum (IDLE, A1…X3), 3-bit+idle encoding;
  - constant NOP_BYTE = 8'h00.
- No sub-module is needed, apart from an optional fetch_timeout counter sub-module.
- The CPU-side tristate join lives in the top level; this block exposes split data_o/data_en.

Test Plan:
- Zero-wait fetch:
  - Stimulus: sync, then A-nibbles 4'h3, 4'h2, 4'h1; store returns 8'hD5 in the same cycle as req.
  - Required response: mem_addr=12'h123; halt never high; M1 data_o=4'hD, M2 data_o=4'h5, data_en high exactly in those 2 cycles.
- 5-cycle store latency:
  - Required response: halt high in M1 for exactly 6 cycles; CPU phase frozen; correct nibbles delivered afterward; mem_req high for 6 cycles.
- Timeout, TIMEOUT_CYCLES=4, store silent:
  - Required response: fetch_err pulses once; M1/M2 drive 4'h0/4'h0; a late mem_valid is ignored; the next instruction cycle fetches normally.
- Resync:
  - Stimulus: sync asserted during X1.
  - Required response: next step is A1; new address captured correctly; stale buffer not driven.
- Reset during stall:
  - Stimulus: reset while in M1 with halt high.
  - Required response: next cycle halt=0, mem_req=0, data_en=0, phase=IDLE; first sync after that restarts cleanly.
- Back-to-back:
  - Stimulus: 3 consecutive instruction cycles to addresses 12'hFFF, 12'h000, 12'h001.
  - Required response: wrap address captured verbatim; all three bytes delivered in order.
